booth_mult_seq: RTL and testbench

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_step.sv | 36 +++
 rtl/booth_mult_seq.sv | 117 +++++++++++
 tb/tb_booth_mult_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoder pair {b_ext[0], E}
  localparam logic [1:0] PAIR_NOP_LO = 2'b00;
  localparam logic [1:0] PAIR_ADD    = 2'b01;
  localparam logic [1:0] PAIR_SUB    = 2'b10;
  localparam logic [1:0] PAIR_NOP_HI = 2'b11;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper accumulator, then arithmetic right shift of {acc_hi, b_ext}.
module booth_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH+1:0] acc_hi_i,
  input  logic [WIDTH:0]   b_ext_i,
  input  logic             e_i,
  input  logic [WIDTH:0]   a_ext_i,
  output logic [WIDTH+1:0] acc_hi_o_c,
  output logic [WIDTH:0]   b_ext_o_c,
  output logic             e_o_c
);
  import booth_pkg::*;

  localparam int unsigned ACC_W = WIDTH + 2;

  logic [ACC_W-1:0] a_wide;
  logic [ACC_W-1:0] sum;

  // Recode the current pair, accumulate, then shift one place right
  always_comb begin
    a_wide = {a_ext_i[WIDTH], a_ext_i};
    case ({b_ext_i[0], e_i})
      PAIR_SUB:    sum = acc_hi_i - a_wide;
      PAIR_ADD:    sum = acc_hi_i + a_wide;
      PAIR_NOP_LO: sum = acc_hi_i;
      PAIR_NOP_HI: sum = acc_hi_i;
      default:     sum = acc_hi_i;
    endcase
    acc_hi_o_c = {sum[ACC_W-1], sum[ACC_W-1:1]};
    b_ext_o_c  = {sum[0], b_ext_i[WIDTH:1]};
    e_o_c      = b_ext_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed/unsigned multiplier, one Booth step per clock.
// Fixed latency of WIDTH+1 RUN cycles; product held until the next run ends.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  import booth_pkg::*;

  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam int unsigned ACC_W  = WIDTH + 2;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH + 1);

  state_t              state_q, state_d;
  logic [EXT_W-1:0]    a_q, a_d;
  logic [EXT_W-1:0]    b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                e_q, e_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    step_acc_c;
  logic [EXT_W-1:0]    step_b_c;
  logic                step_e_c;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi_i   (acc_q),
    .b_ext_i    (b_q),
    .e_i        (e_q),
    .a_ext_i    (a_q),
    .acc_hi_o_c (step_acc_c),
    .b_ext_o_c  (step_b_c),
    .e_o_c      (step_e_c)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      e_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, operand capture and step sequencing
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = tc ? {a[WIDTH-1], a} : {1'b0, a};
          b_d     = tc ? {b[WIDTH-1], b} : {1'b0, b};
          acc_d   = '0;
          e_d     = 1'b0;
          cnt_d   = STEPS;
        end
      end
      RUN: begin
        acc_d = step_acc_c;
        b_d   = step_b_c;
        e_d   = step_e_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // Low 2*WIDTH bits of the shifted {acc_hi, b_ext} result
          p_d     = {step_acc_c[WIDTH-2:0], step_b_c};
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench: WIDTH=16 (directed + random) and WIDTH=8 (random) instances.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16_n, start16, tc16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        rst8_n, start8, tc8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;
  longint q16[$];
  longint q8[$];
  bit drv8_fin = 1'b0;
  logic rst16_s = 1'b0;
  logic [31:0] prev_p16 = '0;

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .start(start16), .tc(tc16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .tc(tc8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  // Reference: integer product of the operands as interpreted by tc, truncated
  function automatic longint ref_mul(input longint av, input longint bv,
                                     input bit tcv, input int w);
    longint mask;
    longint x;
    longint y;
    mask = (longint'(1) << w) - 1;
    x = av & mask;
    y = bv & mask;
    if (tcv) begin
      if (x[w-1]) x = x - (longint'(1) << w);
      if (y[w-1]) y = y - (longint'(1) << w);
    end
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] corner [6];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] corner [5];
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expected product whenever a done pulse appears
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p16_unexpected_done: got p=%0h expected no done", p16);
      end else begin
        check("p16", longint'(p16), q16.pop_front());
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL p8_unexpected_done: got p=%0h expected no done", p8);
      end else begin
        check("p8", longint'(p8), q8.pop_front());
      end
    end
  end

  // Product may only move together with a done pulse (reset aside)
  always @(posedge clk) rst16_s <= rst16_n;
  always @(negedge clk) begin
    if (rst16_s === 1'b1 && done16 === 1'b0)
      check("p16_hold", longint'(p16), longint'(prev_p16));
    prev_p16 <= p16;
  end

  task automatic launch16(input logic [15:0] av, input logic [15:0] bv,
                          input logic tcv, input longint exp, input bit push);
    a16 = av;
    b16 = bv;
    tc16 = tcv;
    start16 = 1'b1;
    if (push) q16.push_back(exp);
    @(posedge clk);
    #1 start16 = 1'b0;
  endtask

  task automatic wait_done16(output int lat, output int bc);
    bit seen;
    seen = 1'b0;
    lat = 0;
    bc = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done16 === 1'b1) seen = 1'b1;
      else begin
        if (busy16 === 1'b1) bc++;
        lat++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done16_timeout: got no done expected done within 100 cycles");
    end
  endtask

  // WIDTH=8 random driver, runs alongside the WIDTH=16 sequence
  initial begin
    int lat;
    bit seen;
    logic [7:0] av;
    logic [7:0] bv;
    logic tcv;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    tc8 = 1'b0;
    wait (rst8_n === 1'b1);
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      av = pick8();
      bv = pick8();
      tcv = 1'($urandom);
      a8 = av;
      b8 = bv;
      tc8 = tcv;
      start8 = 1'b1;
      q8.push_back(ref_mul(longint'(av), longint'(bv), tcv, 8));
      @(posedge clk);
      #1 start8 = 1'b0;
      seen = 1'b0;
      lat = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (done8 === 1'b1) seen = 1'b1;
        else lat++;
      end
      check("lat8", longint'(lat), 9);
    end
    drv8_fin = 1'b1;
  end

  initial begin
    int lat;
    int bc;
    logic [15:0] av;
    logic [15:0] bv;
    logic tcv;
    rst16_n = 1'b0;
    rst8_n = 1'b0;
    start16 = 1'b0;
    tc16 = 1'b0;
    a16 = '0;
    b16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy16", longint'(busy16), 0);
    check("rst_done16", longint'(done16), 0);
    check("rst_p16", longint'(p16), 0);
    check("rst_busy8", longint'(busy8), 0);
    check("rst_done8", longint'(done8), 0);
    check("rst_p8", longint'(p8), 0);
    rst16_n = 1'b1;
    rst8_n = 1'b1;
    @(negedge clk);

    // 3 * -5 signed: latency and busy window
    launch16(16'd3, 16'hFFFB, 1'b1, 64'hFFFF_FFF1, 1'b1);
    wait_done16(lat, bc);
    check("latency_3x-5", longint'(lat), 17);
    check("busy_cycles_3x-5", longint'(bc), 17);

    // Most-negative and all-ones corners
    launch16(16'h8000, 16'h8000, 1'b1, 64'h4000_0000, 1'b1);
    wait_done16(lat, bc);
    launch16(16'h8000, 16'h7FFF, 1'b1, 64'hC000_8000, 1'b1);
    wait_done16(lat, bc);
    launch16(16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE_0001, 1'b1);
    wait_done16(lat, bc);
    launch16(16'hFFFF, 16'hFFFF, 1'b1, 64'h0000_0001, 1'b1);
    wait_done16(lat, bc);
    @(negedge clk);

    // Start pulsed in RUN cycle 5 must be ignored
    launch16(16'd7, 16'd9, 1'b0, 64'd63, 1'b1);
    repeat (5) @(negedge clk);
    a16 = 16'd2;
    b16 = 16'd2;
    start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    wait_done16(lat, bc);
    check("ignored_start_latency", longint'(lat), 12);
    @(negedge clk);
    check("after_done_busy", longint'(busy16), 0);
    check("after_done_done", longint'(done16), 0);

    // Back-to-back: start held through DONE, p holds 63 during second run
    launch16(16'd7, 16'd9, 1'b0, 64'd63, 1'b1);
    wait_done16(lat, bc);
    launch16(16'd5, 16'd6, 1'b1, 64'd30, 1'b1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("b2b_busy", longint'(busy16), 1);
      check("b2b_p_hold", longint'(p16), 63);
    end
    wait_done16(lat, bc);
    check("b2b_done_latency", longint'(lat), 0);

    // Reset in RUN cycle 8 with start also high: abort, no done
    launch16(16'd11, 16'd13, 1'b0, 64'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst16_n = 1'b0;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    rst16_n = 1'b1;
    start16 = 1'b0;
    @(negedge clk);
    check("abort_busy", longint'(busy16), 0);
    check("abort_done", longint'(done16), 0);
    check("abort_p", longint'(p16), 0);
    repeat (25) begin
      @(negedge clk);
      check("abort_idle_busy", longint'(busy16), 0);
    end

    // Random signed/unsigned operands
    for (int n = 0; n < 2000; n++) begin
      av = pick16();
      bv = pick16();
      tcv = 1'($urandom);
      launch16(av, bv, tcv, ref_mul(longint'(av), longint'(bv), tcv, 16), 1'b1);
      wait_done16(lat, bc);
      check("lat16", longint'(lat), 17);
    end

    for (int i = 0; i < 100000 && !drv8_fin; i++) @(negedge clk);
    if (!drv8_fin) begin
      checks++;
      errors++;
      $display("FAIL drv8_timeout: got unfinished expected finished");
    end
    repeat (2) @(negedge clk);
    check("q16_empty", longint'(q16.size()), 0);
    check("q8_empty", longint'(q8.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
